// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch sequencer states, operand length codes and opcode length field position
package fetch_pkg;
    typedef enum logic [1:0] {FETCH_OP, FETCH_LO, FETCH_HI, HOLD} state_e;
    localparam logic [1:0] LEN_0 = 2'd0;
    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_RSVD = 2'd3;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 6;
endpackage

// File: rtl/opcode_length.sv
// opcode_length: opcode length field in -> operand byte count (length) and reserved-code flag (illegal) out
module opcode_length
    import fetch_pkg::*;
(
    input  logic [1:0] len_field,
    output logic [1:0] length,
    output logic       illegal
);
    always_comb begin
        illegal = len_field == LEN_RSVD;
        length  = illegal ? LEN_0 : len_field;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: takes opcode + 0-2 operand bytes (mem_data/mem_wait), drives PC assert/inc, presents instr_valid/opcode/operand/illegal to decoder (instr_ready, flush)
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    input  logic                      mem_wait,
    input  logic                      flush,
    input  logic                      instr_ready,
    output logic                      pc_assert_addr,
    output logic                      pc_inc,
    output logic                      instr_valid,
    output logic [DATA_WIDTH-1:0]     opcode,
    output logic [2*DATA_WIDTH-1:0]   operand,
    output logic                      illegal
);
    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
    logic [2*DATA_WIDTH-1:0] operand_q, operand_d;
    logic                    illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0]   len_src;
    logic [1:0]              length;
    logic                    len_illegal;

    opcode_length u_len (
        .len_field(len_src[LEN_MSB:LEN_LSB]),
        .length   (length),
        .illegal  (len_illegal)
    );

    always_comb begin
        len_src        = state_q == FETCH_OP ? mem_data : opcode_q;
        pc_assert_addr = state_q != HOLD && !flush && !reset;
        pc_inc         = pc_assert_addr && !mem_wait;
        state_d        = state_q;
        opcode_d       = opcode_q;
        operand_d      = operand_q;
        illegal_d      = illegal_q;
        if (flush) begin
            state_d   = FETCH_OP;
            opcode_d  = '0;
            operand_d = '0;
            illegal_d = 1'b0;
        end else if (pc_inc) begin
            case (state_q)
                FETCH_OP: begin
                    opcode_d  = mem_data;
                    operand_d = '0;
                    illegal_d = len_illegal;
                    state_d   = length == LEN_0 ? HOLD : FETCH_LO;
                end
                FETCH_LO: begin
                    operand_d[DATA_WIDTH-1:0] = mem_data;
                    state_d = length == LEN_2 ? FETCH_HI : HOLD;
                end
                default: begin
                    operand_d[2*DATA_WIDTH-1:DATA_WIDTH] = mem_data;
                    state_d = HOLD;
                end
            endcase
        end else if (state_q == HOLD && instr_ready) begin
            state_d = FETCH_OP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH_OP;
            opcode_q  <= '0;
            operand_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_valid = state_q == HOLD;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign illegal     = illegal_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table plus randomized run against a byte-counting reference model
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  mem_data = '0;
    logic        mem_wait = 1'b0;
    logic        flush = 1'b0;
    logic        instr_ready = 1'b0;
    logic        pc_assert_addr, pc_inc, instr_valid, illegal;
    logic [7:0]  opcode;
    logic [15:0] operand;

    int tests = 0;
    int fails = 0;

    fetch_sequencer #(.DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .mem_data(mem_data), .mem_wait(mem_wait),
        .flush(flush), .instr_ready(instr_ready), .pc_assert_addr(pc_assert_addr),
        .pc_inc(pc_inc), .instr_valid(instr_valid), .opcode(opcode),
        .operand(operand), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r, f, w;
        logic [7:0]  d;
        logic        rdy;
        logic        ea, ei, ev;
        logic [7:0]  op;
        logic [15:0] opd;
        logic        il;
    } vec_t;

    vec_t vecs[$];

    // reference model: counts bytes taken for the instruction in progress
    bit          m_valid = 0;
    int          m_got = 0;
    int          m_need = 0;
    logic [7:0]  m_op = '0;
    logic [15:0] m_opd = '0;
    logic        m_ill = 1'b0;

    function automatic vec_t v(logic r, logic f, logic w, logic [7:0] d, logic rdy,
                               logic ea, logic ei, logic ev, logic [7:0] op,
                               logic [15:0] opd, logic il);
        vec_t t;
        t = '{r, f, w, d, rdy, ea, ei, ev, op, opd, il};
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic f, input logic w,
                              input logic [7:0] d, input logic rdy);
        if (r) begin
            m_valid = 0; m_got = 0; m_op = 0; m_opd = 0; m_ill = 0;
        end else if (f) begin
            m_valid = 0; m_got = 0;
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 0; m_got = 0;
            end
        end else if (!w) begin
            if (m_got == 0) begin
                m_op = d;
                m_opd = 0;
                m_ill = d[7:6] == 2'b11;
                m_need = m_ill ? 0 : int'(d[7:6]);
            end else begin
                m_opd = m_opd | (16'(d) << (8 * (m_got - 1)));
            end
            m_got++;
            if (m_got == 1 + m_need) m_valid = 1;
        end
    endtask

    task automatic step(input vec_t t, input bit use_tab);
        logic ea, ei;
        @(negedge clk);
        reset = t.r; flush = t.f; mem_wait = t.w; mem_data = t.d; instr_ready = t.rdy;
        #1;
        ea = !t.r && !t.f && !m_valid;
        ei = ea && !t.w;
        if (use_tab) begin
            ea = t.ea;
            ei = t.ei;
        end
        chk("pc_assert_addr", 16'(pc_assert_addr), 16'(ea));
        chk("pc_inc", 16'(pc_inc), 16'(ei));
        @(posedge clk);
        model_edge(t.r, t.f, t.w, t.d, t.rdy);
        #1;
        if (use_tab) begin
            chk("instr_valid", 16'(instr_valid), 16'(t.ev));
            if (t.ev || t.r) begin
                chk("opcode", 16'(opcode), 16'(t.op));
                chk("operand", operand, t.opd);
                chk("illegal", 16'(illegal), 16'(t.il));
            end
        end else begin
            chk("instr_valid", 16'(instr_valid), 16'(m_valid));
            if (m_valid || t.r) begin
                chk("opcode", 16'(opcode), 16'(m_op));
                chk("operand", operand, m_opd);
                chk("illegal", 16'(illegal), 16'(m_ill));
            end
        end
    endtask

    initial begin
        //            r f w d      rdy ea ei ev op     opd        il
        vecs.push_back(v(1,0,0,8'h00,0, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h05,0, 1,1,1,8'h05,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h00,1, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h83,0, 1,1,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h34,0, 1,1,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h12,0, 1,1,1,8'h83,16'h1234,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(v(0,0,0,8'hEE,0, 0,0,1,8'h83,16'h1234,0));
        vecs.push_back(v(0,0,0,8'hEE,1, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h41,0, 1,1,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,1,8'hAB,0, 1,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,1,8'hAB,0, 1,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'hAB,0, 1,1,1,8'h41,16'h00AB,0));
        vecs.push_back(v(0,0,0,8'h00,1, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h83,0, 1,1,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h34,0, 1,1,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,1,0,8'h12,0, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h07,1, 1,1,1,8'h07,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h00,1, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'hC2,1, 1,1,1,8'hC2,16'h0000,1));
        vecs.push_back(v(0,0,0,8'h00,1, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h10,0, 1,1,1,8'h10,16'h0000,0));
        vecs.push_back(v(0,1,0,8'h00,1, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,0,8'h06,0, 1,1,1,8'h06,16'h0000,0));
        vecs.push_back(v(1,0,0,8'h00,1, 0,0,0,8'h00,16'h0000,0));
        vecs.push_back(v(0,0,1,8'h9A,0, 1,0,0,8'h00,16'h0000,0));

        foreach (vecs[i]) step(vecs[i], 1'b1);

        step(v(1,0,0,8'h00,0, 0,0,0,8'h00,16'h0000,0), 1'b0);
        for (int i = 0; i < 600; i++) begin
            vec_t t;
            t = '0;
            t.r   = $urandom_range(0, 63) == 0;
            t.f   = $urandom_range(0, 15) == 0;
            t.w   = $urandom_range(0, 3) == 0;
            t.d   = 8'($urandom);
            t.rdy = $urandom_range(0, 1) == 1;
            step(t, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer for the 8-bit-data / 16-bit-address CPU. It sits directly upstream of the program-counter address register. It drives that register's address-bus assert and increment controls, captures the opcode byte and 0–2 operand bytes from memory, and presents one assembled instruction to the decoder over a valid/ready handshake. The decoder redirects fetch after a jump by loading the PC and pulsing `flush`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: memory byte width; the operand is 2×`DATA_WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_data`  in  `DATA_WIDTH`  memory read data for the address currently on the address bus; combinational, valid in the same cycle.
- `mem_wait`  in  1  memory not ready; the current byte is not taken this cycle.
- `flush`  in  1  abandon the current fetch; PC is being reloaded this cycle.
- `instr_ready`  in  1  decoder accepts the presented instruction.
- `pc_assert_addr`  out  1  drives PC `assert_addr`.
- `pc_inc`  out  1  drives PC `inc`.
- `instr_valid`  out  1  assembled instruction available.
- `opcode`  out  `DATA_WIDTH`  captured opcode.
- `operand`  out  2×`DATA_WIDTH`  captured operand, zero-extended.
- `illegal`  out  1  opcode uses the reserved length code; qualified by `instr_valid`.

## Operation
- States: FETCH_OP, FETCH_LO, FETCH_HI, HOLD.
- Operand length is `opcode[7:6]`:
  - 00 → 0 bytes
  - 01 → 1 byte
  - 10 → 2 bytes
  - 11 → reserved: 0 bytes, `illegal`=1
- Byte take: in any FETCH_* state with `reset`=0, `flush`=0 and `mem_wait`=0, the byte on `mem_data` is captured at the edge and `pc_inc`=1, so PC advances one address per byte taken.
- FETCH_OP take:
  - `opcode`←`mem_data`, `operand`←0, `illegal`←(`mem_data[7:6]`==11).
  - Next state is FETCH_LO if length ≥1, otherwise HOLD.
- FETCH_LO take: `operand[7:0]`←`mem_data`. Next state is FETCH_HI if length=2, otherwise HOLD.
- FETCH_HI take: `operand[15:8]`←`mem_data`; next state HOLD. Operands are little-endian.
- HOLD:
  - `instr_valid`=1, `pc_assert_addr`=0, `pc_inc`=0.
  - On `instr_valid`&`instr_ready` at an edge, the next state is FETCH_OP.
  - `opcode`, `operand` and `illegal` stay stable until then.
- `mem_wait`=1 in a FETCH_* state: state and captured data hold, `pc_inc`=0, `pc_assert_addr` stays 1.
- `flush`=1, any state:
  - `pc_assert_addr`=0 and `pc_inc`=0 combinationally in that cycle; next state FETCH_OP.
  - Captured data is discarded.
  - A handshake in the same cycle is not an acceptance; the decoder issuing `flush` ignores it.
- Priority: `reset` > `flush` > `mem_wait` > normal sequencing.

## Timing
- Reset values: state FETCH_OP, `opcode`=0, `operand`=0, `illegal`=0, `instr_valid`=0.
- While `reset`=1: `pc_assert_addr`=0 and `pc_inc`=0. Fetching starts the first cycle after reset deasserts.
- `pc_assert_addr` = in FETCH_* & !`flush` & !`reset`.
- `pc_inc` = `pc_assert_addr` & !`mem_wait`. Both are combinational from state and inputs.
- `instr_valid` = (state==HOLD); registered, with no combinational path from inputs.
- Latency with no waits, counted from entering FETCH_OP to `instr_valid` high: 1 + length cycles.
- Minimum period between instructions is 2 + length cycles (HOLD takes one cycle).
- `instr_ready` may be held high permanently; acceptance takes effect at the edge.
- Reset or flush mid-operation: completes abandonment within one edge. No partial instruction is ever presented.

## Structure
- Package `fetch_pkg`:
  - state enum (FETCH_OP, FETCH_LO, FETCH_HI, HOLD)
  - length-code constants LEN_0, LEN_1, LEN_2, LEN_RSVD
  - opcode length field position [7:6]
- Sub-module `opcode_length`: combinational `opcode` → {length[1:0], illegal}. It is shared with the decoder.

## Test plan
- 0-operand: release reset, `mem_data`=0x05 → `pc_inc` high for 1 cycle; next cycle `instr_valid`=1, `opcode`=0x05, `operand`=0x0000.
- 2-operand: bytes 0x83, 0x34, 0x12 → 3 consecutive `pc_inc` pulses, then `instr_valid` with `opcode`=0x83, `operand`=0x1234; `instr_ready`=0 for 4 cycles → outputs stable, `pc_inc`=0.
- Wait states: 1-operand 0x41, 0xAB with `mem_wait`=1 for 2 cycles on the operand byte → `pc_inc` low those cycles, 2 pulses total, `operand`=0x00AB.
- Flush: `flush` asserted in FETCH_HI → no `pc_inc` that cycle, next state FETCH_OP; following byte 0x07 produces `opcode`=0x07 with no stale operand.
- Reserved opcode 0xC2 → length 0, `instr_valid`=1, `illegal`=1; next opcode 0x10 → `illegal`=0.
- `reset` asserted in HOLD with `instr_ready`=1 → no acceptance; all outputs at reset values the next cycle.
